diagonal_coord_tag: RTL and testbench

DIAGONAL_COORD_TAG -- requirements
Module: diagonal_coord_tag

---
 rtl/diagonal_coord_tag.sv | 135 +++++++++++++
 tb/tb_diagonal_coord_tag.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/diagonal_coord_tag.sv
// Tags a diagonal-ordered sample stream with (x,y,z,t) coordinates and a computed last flag.
// Optional COORD_CHECK_EN adds a sticky err_last output comparing input last against the computed one.
module diagonal_coord_tag #(
  parameter int MAX_X_WIDTH = 10,
  parameter int MAX_Y_WIDTH = 8,
  parameter int MAX_Z_WIDTH = 9,
  parameter int MAX_T_WIDTH = 18,
  parameter int DATA_WIDTH  = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [MAX_X_WIDTH-1:0] cfg_max_x,
  input  logic [MAX_Y_WIDTH-1:0] cfg_max_y,
  input  logic [MAX_Z_WIDTH-1:0] cfg_max_z,
  input  logic [MAX_T_WIDTH-1:0] cfg_max_t,
  input  logic [DATA_WIDTH-1:0]  axis_input_d,
  input  logic [5:0]             axis_input_flags,
  input  logic                   axis_input_last,
  input  logic                   axis_input_valid,
  output logic                   axis_input_ready,
  output logic [DATA_WIDTH-1:0]  axis_output_d,
  output logic [5:0]             axis_output_flags,
  output logic [MAX_X_WIDTH-1:0] axis_output_x,
  output logic [MAX_Y_WIDTH-1:0] axis_output_y,
  output logic [MAX_Z_WIDTH-1:0] axis_output_z,
  output logic [MAX_T_WIDTH-1:0] axis_output_t,
  output logic                   axis_output_diag_first,
  output logic                   axis_output_last,
  output logic                   axis_output_valid,
  input  logic                   axis_output_ready,
  output logic                   finished
`ifdef COORD_CHECK_EN
  ,
  output logic                   err_last
`endif
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state_q, state_d;

  logic [MAX_Z_WIDTH-1:0] z_q, z_d, zs_q, zs_d;
  logic [MAX_T_WIDTH-1:0] t_q, t_d, st_q, st_d;
  logic [MAX_X_WIDTH-1:0] x_q, x_d, sx_q, sx_d, x_inc, sx_inc;
  logic [MAX_Y_WIDTH-1:0] y_q, y_d, sy_q, sy_d, y_inc, sy_inc;
  logic first_q, first_d;
  logic in_hs, out_hs, diag_end, tag_last;

  // cfg_max_y only bounds the frame implicitly through cfg_max_t.
  logic unused_cfg;
  assign unused_cfg = ^cfg_max_y;

  assign finished         = (state_q == DONE);
  assign axis_input_ready = rst && !finished && (!axis_output_valid || axis_output_ready);
  assign in_hs            = axis_input_valid && axis_input_ready;
  assign out_hs           = axis_output_valid && axis_output_ready;
  assign diag_end         = (z_q == '0) || (t_q == cfg_max_t);
  assign tag_last         = (z_q == cfg_max_z) && (t_q == cfg_max_t);

  // t+1 as a raster step: wrap x at max_x and carry into y.
  assign x_inc  = (x_q == cfg_max_x)  ? '0 : x_q + 1'b1;
  assign y_inc  = (x_q == cfg_max_x)  ? y_q + 1'b1 : y_q;
  assign sx_inc = (sx_q == cfg_max_x) ? '0 : sx_q + 1'b1;
  assign sy_inc = (sx_q == cfg_max_x) ? sy_q + 1'b1 : sy_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_hs) state_d = RUN;
      RUN:     if (out_hs && axis_output_last) state_d = DONE;
      default: state_d = DONE;
    endcase
  end

  // Registers hold the tag for the next accepted sample; zs is the start z of the current diagonal.
  always_comb begin
    z_d = z_q; t_d = t_q; x_d = x_q; y_d = y_q;
    zs_d = zs_q; st_d = st_q; sx_d = sx_q; sy_d = sy_q;
    first_d = first_q;
    if (in_hs) begin
      first_d = diag_end;
      if (!diag_end) begin
        z_d = z_q - 1'b1; t_d = t_q + 1'b1; x_d = x_inc; y_d = y_inc;
      end else if (zs_q != cfg_max_z) begin
        zs_d = zs_q + 1'b1; z_d = zs_q + 1'b1;
        t_d = '0; x_d = '0; y_d = '0; st_d = '0; sx_d = '0; sy_d = '0;
      end else begin
        z_d = cfg_max_z;
        st_d = st_q + 1'b1; sx_d = sx_inc; sy_d = sy_inc;
        t_d = st_q + 1'b1;  x_d = sx_inc;  y_d = sy_inc;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      z_q <= '0; t_q <= '0; x_q <= '0; y_q <= '0;
      zs_q <= '0; st_q <= '0; sx_q <= '0; sy_q <= '0;
      first_q <= 1'b1;
      axis_output_valid <= 1'b0;
      axis_output_d <= '0; axis_output_flags <= '0;
      axis_output_x <= '0; axis_output_y <= '0; axis_output_z <= '0; axis_output_t <= '0;
      axis_output_diag_first <= 1'b0; axis_output_last <= 1'b0;
    end else begin
      state_q <= state_d;
      z_q <= z_d; t_q <= t_d; x_q <= x_d; y_q <= y_d;
      zs_q <= zs_d; st_q <= st_d; sx_q <= sx_d; sy_q <= sy_d;
      first_q <= first_d;
      if (in_hs) begin
        axis_output_valid      <= 1'b1;
        axis_output_d          <= axis_input_d;
        axis_output_flags      <= axis_input_flags;
        axis_output_x          <= x_q;
        axis_output_y          <= y_q;
        axis_output_z          <= z_q;
        axis_output_t          <= t_q;
        axis_output_diag_first <= first_q;
        axis_output_last       <= tag_last;
      end else if (axis_output_ready) begin
        axis_output_valid <= 1'b0;
      end
    end
  end

`ifdef COORD_CHECK_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                      err_last <= 1'b0;
    else if (in_hs && (axis_input_last != tag_last)) err_last <= 1'b1;
  end
`else
  logic unused_last;
  assign unused_last = axis_input_last;
`endif

endmodule

// File: tb/tb_diagonal_coord_tag.sv
// Directed bench for diagonal_coord_tag: hand-computed tag table plus an independent diagonal-order model.
module tb_diagonal_coord_tag;
  localparam int XW = 10, YW = 8, ZW = 9, TW = 18, DW = 16;

  logic clk = 1'b0, rst = 1'b0;
  always #5 clk = ~clk;

  logic [XW-1:0] cfg_max_x = XW'(5);
  logic [YW-1:0] cfg_max_y = YW'(7);
  logic [ZW-1:0] cfg_max_z = ZW'(2);
  logic [TW-1:0] cfg_max_t = TW'(47);
  logic [DW-1:0] in_d = '0;
  logic [5:0]    in_flags = '0;
  logic          in_last = 1'b0, in_valid = 1'b0, in_ready;
  logic [DW-1:0] out_d;
  logic [5:0]    out_flags;
  logic [XW-1:0] out_x;
  logic [YW-1:0] out_y;
  logic [ZW-1:0] out_z;
  logic [TW-1:0] out_t;
  logic          out_first, out_last, out_valid, out_ready = 1'b0, finished;
`ifdef COORD_CHECK_EN
  logic          err_last;
`endif

  diagonal_coord_tag dut (
    .clk(clk), .rst(rst),
    .cfg_max_x(cfg_max_x), .cfg_max_y(cfg_max_y), .cfg_max_z(cfg_max_z), .cfg_max_t(cfg_max_t),
    .axis_input_d(in_d), .axis_input_flags(in_flags), .axis_input_last(in_last),
    .axis_input_valid(in_valid), .axis_input_ready(in_ready),
    .axis_output_d(out_d), .axis_output_flags(out_flags),
    .axis_output_x(out_x), .axis_output_y(out_y), .axis_output_z(out_z), .axis_output_t(out_t),
    .axis_output_diag_first(out_first), .axis_output_last(out_last),
    .axis_output_valid(out_valid), .axis_output_ready(out_ready),
    .finished(finished)
`ifdef COORD_CHECK_EN
    , .err_last(err_last)
`endif
  );

  typedef struct { int z; int t; int x; int y; bit f; bit l; } tag_t;
  typedef struct { int idx; int z; int t; int x; int y; bit f; bit l; } vec_t;

  tag_t expq [0:255];
  tag_t cap  [0:255];
  int   n_exp;
  int   n_chk = 0, n_fail = 0;
  int   bad_idx = -1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] pk(input int z, input int t, input int x, input int y, input bit f, input bit l);
    return 64'({ZW'(z), TW'(t), XW'(x), YW'(y), f, l});
  endfunction

  function automatic logic [63:0] pk_out();
    return 64'({out_z, out_t, out_x, out_y, out_first, out_last});
  endfunction

  // Enumerate diagonals directly: d = z + t, z descending from min(d, mz), stop once t exceeds mt.
  function automatic void build(input int mx, input int mz, input int mt);
    n_exp = 0;
    for (int d = 0; d <= mt + mz; d++) begin
      bit f = 1'b1;
      for (int z = (d < mz) ? d : mz; z >= 0; z--) begin
        int t = d - z;
        if (t > mt) break;
        expq[n_exp].z = z; expq[n_exp].t = t;
        expq[n_exp].x = t % (mx + 1); expq[n_exp].y = t / (mx + 1);
        expq[n_exp].f = f; expq[n_exp].l = (z == mz) && (t == mt);
        f = 1'b0;
        n_exp++;
      end
    end
  endfunction

  task automatic do_reset(input int mz, input int mt);
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    cfg_max_z = ZW'(mz); cfg_max_t = TW'(mt);
    build(5, mz, mt);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic stream(input int total, input bit rnd);
    int sent = 0, got = 0, guard = 0;
    bit stall = 1'b0;
    logic [63:0] hold_tag, hold_pay;
    while (got < total && guard < 5000) begin
      guard++;
      in_valid  = (sent < total) && (!rnd || $urandom_range(0, 1) == 1);
      in_d      = DW'(sent);
      in_flags  = 6'(sent);
      in_last   = expq[sent].l ^ (sent == bad_idx);
      out_ready = !rnd || $urandom_range(0, 1) == 1;
      #1;
      if (stall) begin
        chk("stall_tag", pk_out(), hold_tag);
        chk("stall_pay", 64'({out_valid, out_flags, out_d}), hold_pay);
      end
      if (out_valid && out_ready) begin
        chk($sformatf("tag[%0d]", got), pk_out(),
            pk(expq[got].z, expq[got].t, expq[got].x, expq[got].y, expq[got].f, expq[got].l));
        chk($sformatf("data[%0d]", got), 64'({out_flags, out_d}), 64'({6'(got), DW'(got)}));
        cap[got].z = int'(out_z); cap[got].t = int'(out_t);
        cap[got].x = int'(out_x); cap[got].y = int'(out_y);
        cap[got].f = out_first;   cap[got].l = out_last;
        got++;
      end
      stall    = out_valid && !out_ready;
      hold_tag = pk_out();
      hold_pay = 64'({1'b1, out_flags, out_d});
      if (in_valid && in_ready) sent++;
      @(posedge clk);
      @(negedge clk);
    end
    in_valid = 1'b0;
    if (got < total) chk("stream_timeout", 64'(got), 64'(total));
  endtask

  task automatic chk_done(input string name);
    out_ready = 1'b1;
    #1;
    chk({name, "_finished"}, 64'(finished), 64'd1);
    chk({name, "_in_ready"}, 64'(in_ready), 64'd0);
    chk({name, "_no_extra"}, 64'(out_valid), 64'd0);
  endtask

  vec_t tbl [10];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{0,   0, 0,  0, 0, 1, 0};
    tbl[1] = '{1,   1, 0,  0, 0, 1, 0};
    tbl[2] = '{2,   0, 1,  1, 0, 0, 0};
    tbl[3] = '{3,   2, 0,  0, 0, 1, 0};
    tbl[4] = '{4,   1, 1,  1, 0, 0, 0};
    tbl[5] = '{5,   0, 2,  2, 0, 0, 0};
    tbl[6] = '{6,   2, 1,  1, 0, 1, 0};
    tbl[7] = '{17,  0, 6,  0, 1, 0, 0};
    tbl[8] = '{140, 0, 47, 5, 7, 0, 0};
    tbl[9] = '{143, 2, 47, 5, 7, 1, 1};

    build(5, 2, 47);
    chk("model_count", 64'(n_exp), 64'd144);
    repeat (2) @(negedge clk);
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_outs", 64'({out_valid, finished, out_d, out_flags}), 64'd0);
    chk("rst_tag", pk_out(), 64'd0);
    rst = 1'b1;
    @(negedge clk);

    // Full stream, ready always high; verify hand-computed points.
    stream(144, 1'b0);
    for (int i = 0; i < 10; i++)
      chk($sformatf("table[%0d]", tbl[i].idx),
          pk(cap[tbl[i].idx].z, cap[tbl[i].idx].t, cap[tbl[i].idx].x, cap[tbl[i].idx].y,
             cap[tbl[i].idx].f, cap[tbl[i].idx].l),
          pk(tbl[i].z, tbl[i].t, tbl[i].x, tbl[i].y, tbl[i].f, tbl[i].l));
    chk_done("full");
    repeat (3) @(negedge clk);
    chk("finished_held", 64'(finished), 64'd1);

    // Random valid / ready with stall stability checks.
    do_reset(2, 47);
    chk("rerun_cleared", 64'(finished), 64'd0);
    stream(144, 1'b1);
    chk_done("random");

    // Reset mid-stream with a sample held in the output register.
    do_reset(2, 47);
    stream(60, 1'b0);
    in_valid = 1'b1; in_d = DW'(60); in_flags = 6'(60); out_ready = 1'b0;
    @(posedge clk); #1;
    chk("pre_rst_valid", 64'(out_valid), 64'd1);
    chk("pre_rst_tag", pk_out(), pk(expq[60].z, expq[60].t, expq[60].x, expq[60].y, expq[60].f, expq[60].l));
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_outs", 64'({out_valid, finished, in_ready, out_d, out_flags}), 64'd0);
    chk("mid_rst_tag", pk_out(), 64'd0);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    stream(5, 1'b0);
    chk("restart_first", 64'({cap[0].z, cap[0].t}), 64'd0);

    // max_z == 0: every sample starts its own diagonal.
    do_reset(0, 3);
    stream(4, 1'b0);
    for (int i = 0; i < 4; i++)
      chk($sformatf("mz0[%0d]", i), pk(cap[i].z, cap[i].t, cap[i].x, cap[i].y, cap[i].f, cap[i].l),
          pk(0, i, i, 0, 1'b1, i == 3));
    chk_done("mz0");

    // max_t == 0: one diagonal per z, t stays 0.
    do_reset(3, 0);
    stream(4, 1'b0);
    for (int i = 0; i < 4; i++)
      chk($sformatf("mt0[%0d]", i), pk(cap[i].z, cap[i].t, cap[i].x, cap[i].y, cap[i].f, cap[i].l),
          pk(i, 0, 0, 0, 1'b1, i == 3));
    chk_done("mt0");

`ifdef COORD_CHECK_EN
    do_reset(2, 47);
    chk("err_rst", 64'(err_last), 64'd0);
    stream(144, 1'b0);
    chk("err_clean", 64'(err_last), 64'd0);
    do_reset(2, 47);
    bad_idx = 9;
    stream(20, 1'b0);
    bad_idx = -1;
    chk("err_set", 64'(err_last), 64'd1);
    repeat (3) @(negedge clk);
    chk("err_hold", 64'(err_last), 64'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
